// File: rtl/proc_seq_ctrl_if.sv
// proc_seq_ctrl_if: instruction-memory fetch handshake between sequencer and imem
interface proc_seq_ctrl_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [7:0]      imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: multicycle fetch/decode/exec/writeback sequencer for the 8-bit 2-opcode-bit datapath
module proc_seq_ctrl #(
  parameter int PC_W      = 8,
  parameter int RESET_PC  = 0,
  parameter int FETCH_TMO = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  proc_seq_ctrl_if.master         bus,
  output logic [1:0]              opcode,
  output logic [1:0]              rd_addr,
  output logic [1:0]              rs_addr,
  output logic [1:0]              rt_addr,
  output logic                    alu_en,
  output logic                    wb_sel,
  output logic                    reg_we,
  output logic                    busy,
  output logic                    halted,
  output logic                    err
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam int CW = $clog2(FETCH_TMO + 1);
  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [7:0]      instr;
  logic [CW-1:0]   cnt;
  logic            is_jmp;
  logic [PC_W-1:0] off;
  assign is_jmp = instr[7:6] == 2'b10;
  assign off    = PC_W'($signed(instr[5:0]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= PC_W'(RESET_PC);
      instr <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH:
          if (bus.imem_ack) begin
            instr <= bus.imem_rdata;
            cnt   <= '0;
            state <= S_DECODE;
          end else begin
            // an ack on the last allowed cycle is taken above, so it beats the timeout
            cnt <= cnt + 1'b1;
            if (cnt == CW'(FETCH_TMO - 1)) state <= S_ERR;
          end
        S_DECODE: state <= S_EXEC;
        S_EXEC:
          if (!is_jmp) state <= S_WB;
          else if (instr[5:0] == '0) state <= S_HALT;
          else begin
            pc    <= pc + off;
            state <= S_FETCH;
          end
        S_WB: begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
        default: ;
      endcase
    end
  end
  assign bus.imem_req  = state == S_FETCH;
  assign bus.imem_addr = pc;
  assign opcode  = instr[7:6];
  assign rd_addr = instr[5:4];
  assign rs_addr = instr[3:2];
  assign rt_addr = instr[1:0];
  assign wb_sel  = instr[6];
  assign alu_en  = state == S_EXEC && !is_jmp;
  assign reg_we  = state == S_WB;
  assign busy    = state inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
  assign halted  = state == S_HALT;
  assign err     = state == S_ERR;
endmodule
